// File: rtl/lbus_master.sv
// Initiator for the 16-bit AIST-LSI local bus: one write, read or poll-until-clear
// command at a time, sequenced through setup/strobe/hold phases with one response each.
module lbus_master #(
  parameter int SETUP        = 2,
  parameter int STROBE       = 3,
  parameter int HOLD         = 2,
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] lbus_a,
  output logic [15:0] lbus_di,
  output logic        lbus_wr,
  output logic        lbus_rd,
  input  logic [15:0] lbus_do
);
  // state  | meaning
  // IDLE   | waiting for a command, cmd_ready high
  // SETUP  | address/data driven, both strobes low
  // STROBE | lbus_wr (write) or lbus_rd (read/poll) high
  // HOLD   | strobes low, address/data unchanged
  // RESP   | response presented until rsp_ready

  localparam int MAX_PH = (SETUP > STROBE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                           : ((STROBE > HOLD) ? STROBE : HOLD);
  localparam int PH_W = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int PC_W = $clog2(POLL_TIMEOUT + 1);

  localparam logic [PH_W-1:0] SETUP_LD  = PH_W'(SETUP - 1);
  localparam logic [PH_W-1:0] STROBE_LD = PH_W'(STROBE - 1);
  localparam logic [PH_W-1:0] HOLD_LD   = PH_W'(HOLD - 1);
  localparam logic [PC_W-1:0] POLL_LAST = PC_W'(POLL_TIMEOUT - 1);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_POLL = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [PC_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic [1:0]        op_q, op_d;
  logic [15:0]       mask_q, mask_d;
  logic [15:0]       a_q, a_d;
  logic [15:0]       di_q, di_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    poll_cnt_d = poll_cnt_q;
    op_d       = op_q;
    mask_d     = mask_q;
    a_d        = a_q;
    di_d       = di_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d       = cmd_op;
          mask_d     = cmd_wdata;
          rdata_d    = 16'h0000;
          poll_cnt_d = '0;
          if (cmd_op == OP_RSV) begin
            // reserved opcode never touches the bus
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d  = S_SETUP;
            ph_cnt_d = SETUP_LD;
            err_d    = 1'b0;
            a_d      = cmd_addr;
            di_d     = (cmd_op == OP_WR) ? cmd_wdata : 16'h0000;
          end
        end
      end

      S_SETUP: begin
        if (ph_cnt_q == '0) begin
          state_d  = S_STROBE;
          ph_cnt_d = STROBE_LD;
          wr_d     = (op_q == OP_WR);
          rd_d     = (op_q != OP_WR);
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end

      S_STROBE: begin
        if (ph_cnt_q == '0) begin
          state_d  = S_HOLD;
          ph_cnt_d = HOLD_LD;
          wr_d     = 1'b0;
          rd_d     = 1'b0;
          if (op_q != OP_WR) begin
            rdata_d = lbus_do;
          end
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end

      S_HOLD: begin
        if (ph_cnt_q == '0) begin
          if (op_q != OP_POLL || (rdata_q & mask_q) == 16'h0000) begin
            state_d = S_RESP;
            err_d   = 1'b0;
          end else if (poll_cnt_q == POLL_LAST) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else begin
            state_d    = S_SETUP;
            ph_cnt_d   = SETUP_LD;
            poll_cnt_d = poll_cnt_q + 1'b1;
          end
        end else begin
          ph_cnt_d = ph_cnt_q - 1'b1;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d    = S_IDLE;
          poll_cnt_d = '0;
          a_d        = 16'h0000;
          di_d       = 16'h0000;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ph_cnt_q   <= '0;
      poll_cnt_q <= '0;
      op_q       <= 2'b00;
      mask_q     <= 16'h0000;
      a_q        <= 16'h0000;
      di_q       <= 16'h0000;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rdata_q    <= 16'h0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_cnt_q   <= ph_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      op_q       <= op_d;
      mask_q     <= mask_d;
      a_q        <= a_d;
      di_q       <= di_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign lbus_a    = a_q;
  assign lbus_di   = di_q;
  assign lbus_wr   = wr_q;
  assign lbus_rd   = rd_q;

endmodule
